// File: rtl/mmio_timer_if.sv
// Data-memory bus seen by the timer: core store strobe, address and data,
// with the combinational read data and address-hit returned to the core.
interface mmio_timer_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        hit;

  modport master (output memwrite, dataadr, writedata, input readdata, hit);
  modport slave  (input memwrite, dataadr, writedata, output readdata, hit);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare, sticky match/overrun
// status and a level interrupt; zero-wait-state reads and writes.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR     = 32'hFFFF_FF00,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  mmio_timer_if.slave bus,
  output logic        irq
);
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic        r_en, r_autoreload, r_irqen;
  logic [7:0]  r_prescale, r_pre_cnt;
  logic [31:0] r_count, r_compare;
  logic        r_match, r_overrun;

  logic        w_hit, w_wr;
  logic        w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_status;
  logic        w_tick, w_match_ev;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_hit         = (bus.dataadr[31:4] == BASE_ADDR[31:4]);
  assign w_wr          = bus.memwrite & w_hit;
  assign w_wr_ctrl     = w_wr & (bus.dataadr[3:2] == REG_CTRL);
  assign w_wr_count    = w_wr & (bus.dataadr[3:2] == REG_COUNT);
  assign w_wr_compare  = w_wr & (bus.dataadr[3:2] == REG_COMPARE);
  assign w_wr_status   = w_wr & (bus.dataadr[3:2] == REG_STATUS);
  assign w_unused_addr = ^bus.dataadr[1:0];

  assign w_tick     = r_en & (r_pre_cnt == r_prescale);
  // A CPU write to COUNT replaces the tick, so no compare happens that cycle
  assign w_match_ev = w_tick & ~w_wr_count & (r_count == r_compare);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en         <= 1'b0;
      r_autoreload <= 1'b0;
      r_irqen      <= 1'b0;
      r_prescale   <= '0;
    end else if (w_wr_ctrl) begin
      r_en         <= bus.writedata[0];
      r_autoreload <= bus.writedata[1];
      r_irqen      <= bus.writedata[2];
      r_prescale   <= bus.writedata[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_pre_cnt <= '0;
    else if (w_wr_ctrl || w_tick) r_pre_cnt <= '0;
    else if (r_en)              r_pre_cnt <= r_pre_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_count <= '0;
    else if (w_wr_count)                  r_count <= bus.writedata;
    else if (w_match_ev && r_autoreload)  r_count <= '0;
    else if (w_tick)                      r_count <= r_count + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_compare <= RESET_COMPARE;
    else if (w_wr_compare) r_compare <= bus.writedata;
  end

  // Hardware set beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_match_ev)                            r_match <= 1'b1;
      else if (w_wr_status && bus.writedata[0])  r_match <= 1'b0;
      if (w_match_ev && r_match)                 r_overrun <= 1'b1;
      else if (w_wr_status && bus.writedata[1])  r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (bus.dataadr[3:2])
        REG_CTRL:    w_rdata = {16'd0, r_prescale, 5'd0, r_irqen, r_autoreload, r_en};
        REG_COUNT:   w_rdata = r_count;
        REG_COMPARE: w_rdata = r_compare;
        REG_STATUS:  w_rdata = {30'd0, r_overrun, r_match};
        default:     w_rdata = '0;
      endcase
    end
  end

  assign bus.readdata = w_rdata;
  assign bus.hit      = w_hit;
  assign irq          = r_match & r_irqen;
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral that responds to the single-cycle MIPS core's data-memory bus (memwrite, dataadr, writedata, readdata).
- Sits beside dmem on the same bus; top-level muxes readdata from this block whenever hit is asserted.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match/overrun status and a level interrupt.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, base of the 16-byte register window; bits [3:0] ignored.
- RESET_COMPARE, 32'hFFFF_FFFF, COMPARE value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  core store strobe, qualified by hit.
- dataadr  input  32  core byte address.
- writedata  input  32  core store data.
- readdata  output  32  register read data, combinational; 0 when hit=0.
- hit  output  1  combinational, dataadr[31:4]==BASE_ADDR[31:4].
- irq  output  1  STATUS.MATCH & CTRL.IRQEN, driven from registers only (glitch-free).

Behaviour:
- Register map, word offset dataadr[3:2]; dataadr[1:0] ignored; all accesses are 32-bit:
  - 0x0 CTRL, RW: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, [15:8] PRESCALE. Other bits read 0.
  - 0x4 COUNT, RW.
  - 0x8 COMPARE, RW.
  - 0xC STATUS: bit0 MATCH, bit1 OVERRUN. Write-1-to-clear; other bits read 0.
- Writes: occur at the clk edge when memwrite & hit.
- Reads: combinational in the same cycle, as the single-cycle core requires.
- Reset (asynchronous, any time including mid-count):
  - CTRL=0, COUNT=0, COMPARE=RESET_COMPARE, STATUS=0, prescaler=0.
  - Therefore irq=0. readdata=0 unless hit.
- Prescaler:
  - 8-bit pre_cnt increments each clk while EN=1.
  - tick = EN & (pre_cnt==PRESCALE); on tick pre_cnt<=0.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - EN=0 freezes pre_cnt and COUNT; both hold their values.
- Count update on tick:
  - If COUNT==COMPARE: set MATCH, and set OVERRUN if MATCH was already 1.
  - Then COUNT <= AUTORELOAD ? 0 : COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - Wrap 32'hFFFF_FFFF -> 0 silently, with no flag.
- Priority and simultaneous events:
  - CPU write to COUNT overrides the tick increment in the same cycle; no match is evaluated that cycle.
  - CPU write to CTRL clears pre_cnt to 0, whatever value EN takes.
  - STATUS W1C in the same cycle as a hardware set: the set wins, so the bit stays 1.
  - A write to COMPARE takes effect from the next cycle's comparison.
- Non-hit stores: no effect. Non-hit reads: readdata=0.
- No stall or handshake: the block always completes in zero wait states.

Test Plan:
- Reset check:
  - Assert reset mid-count with EN=1, COUNT=0x55.
  - Expect COUNT=0, STATUS=0, irq=0 and COMPARE=0xFFFF_FFFF immediately, without waiting for a clk edge.
- Basic match with autoreload:
  - Write COMPARE=3, then CTRL=0x7 (EN, AUTORELOAD, IRQEN, PRESCALE=0).
  - Expect COUNT to go 0,1,2,3,0,1 on successive edges.
  - Expect MATCH=1 and irq=1 at the edge where COUNT leaves 3.
- Prescale:
  - Write CTRL=0x0201 (PRESCALE=2, EN).
  - Expect COUNT to increment exactly every 3rd clk; 9 cycles give COUNT=3.
- Overrun and W1C race:
  - Let MATCH set, then let it set again without clearing; expect OVERRUN=1.
  - Write STATUS=0x3 on a cycle with no tick; expect STATUS=0 and irq=0.
  - Repeat the write on a cycle where a match tick occurs; expect MATCH stays 1.
- Wrap and write priority:
  - Write COUNT=0xFFFF_FFFF with AUTORELOAD=0 and COMPARE=5; expect COUNT=0 after the next tick, no MATCH.
  - Write COUNT=0x10 on a tick cycle; expect COUNT=0x10, not 0x11.
- Address decode:
  - Store to BASE_ADDR+0x10 and to 0x0000_0040; expect hit=0, no register change, readdata=0.
  - Read BASE_ADDR+0x9 (unaligned); expect COMPARE returned.
